// File: rtl/wb_config_ctrl.sv
// Wishbone register window that serialises 32-bit words LSB-first onto a masked
// set of configuration column chains, with optional auto-set and status readback.
module wb_config_ctrl #(
    parameter int unsigned NUM_COLS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_addr_i,
    input  logic [31:0]         wbs_data_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_data_o,
    output logic                cfg_cen_o,
    output logic [NUM_COLS-1:0] cfg_shift_o,
    output logic [NUM_COLS-1:0] cfg_shift_en_o,
    output logic [NUM_COLS-1:0] cfg_set_o
);
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 5;
    localparam int unsigned CW = 16;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_MASK   = 2'd1;
    localparam logic [1:0] OFF_DATA   = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_SETP} state_e;

    state_e              state_q, state_d;
    logic [DW-1:0]       sr_q, sr_d;
    logic [LW-1:0]       left_q, left_d;
    logic [LW-1:0]       len_q, len_d;
    logic                cen_q, cen_d;
    logic                auto_q, auto_d;
    logic [NUM_COLS-1:0] mask_q, mask_d;
    logic                err_q, err_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                setp_q, setp_d;
    logic [NUM_COLS-1:0] shift_q, shift_d;
    logic [NUM_COLS-1:0] shen_q, shen_d;
    logic [NUM_COLS-1:0] set_q, set_d;

    logic                hit;
    logic                free;
    logic                err_set;
    logic                clr;
    logic [DW-1:0]       mask_wr;
    logic                unused_ok;

    assign hit = wbs_cyc_i && wbs_stb_i && !ack_q && (wbs_addr_i[31:4] == BASE_ADDR[31:4]);
    // FSM will be idle after this edge, so a DATA write can be taken without a gap
    assign free = (state_q == ST_IDLE) || (state_q == ST_SETP) ||
                  ((state_q == ST_SHIFT) && (left_q == '0) && !auto_q);
    assign unused_ok = ^{wbs_addr_i[1:0], mask_wr};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        left_d  = left_q;
        len_d   = len_q;
        cen_d   = cen_q;
        auto_d  = auto_q;
        mask_d  = mask_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        busy_d  = (state_q != ST_IDLE);
        ack_d   = 1'b0;
        rdata_d = '0;
        setp_d  = 1'b0;
        shift_d = '0;
        shen_d  = '0;
        set_d   = '0;
        err_set = 1'b0;
        clr     = 1'b0;
        mask_wr = DW'(mask_q);

        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
                mask_wr[8*b +: 8] = wbs_data_i[8*b +: 8];
            end
        end

        case (state_q)
            ST_SHIFT: begin
                shen_d  = mask_q;
                shift_d = sr_q[0] ? mask_q : '0;
                sr_d    = {1'b0, sr_q[DW-1:1]};
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (left_q == '0) begin
                    state_d = auto_q ? ST_SETP : ST_IDLE;
                end else begin
                    left_d = left_q - LW'(1);
                end
            end
            ST_SETP: begin
                set_d   = mask_q;
                state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (setp_q) begin
            set_d = mask_q;
        end

        if (hit) begin
            case (wbs_addr_i[3:2])
                OFF_CTRL: begin
                    ack_d = 1'b1;
                    if (wbs_we_i) begin
                        if (wbs_sel_i[0]) begin
                            cen_d  = wbs_data_i[0];
                            auto_d = wbs_data_i[2];
                            clr    = wbs_data_i[3];
                            if (wbs_data_i[1]) begin
                                if (state_q == ST_IDLE) setp_d  = 1'b1;
                                else                    err_set = 1'b1;
                            end
                        end
                        if (wbs_sel_i[1]) begin
                            len_d = wbs_data_i[12:8];
                        end
                    end else begin
                        rdata_d = {19'b0, len_q, 5'b0, auto_q, 1'b0, cen_q};
                    end
                end
                OFF_MASK: begin
                    ack_d = 1'b1;
                    if (wbs_we_i) mask_d  = mask_wr[NUM_COLS-1:0];
                    else          rdata_d = DW'(mask_q);
                end
                OFF_DATA: begin
                    // busy DATA writes stall; reads are never stalled
                    if (!wbs_we_i) begin
                        ack_d = 1'b1;
                    end else if (free) begin
                        ack_d = 1'b1;
                        if ((wbs_sel_i != 4'hF) || !cen_q) begin
                            err_set = 1'b1;
                        end else begin
                            sr_d    = wbs_data_i;
                            left_d  = len_q;
                            state_d = ST_SHIFT;
                        end
                    end
                end
                OFF_STATUS: begin
                    ack_d = 1'b1;
                    if (!wbs_we_i) rdata_d = {cnt_q, 14'b0, err_q, busy_q};
                end
                default: ;
            endcase
        end

        if (clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            left_q  <= '0;
            len_q   <= '0;
            cen_q   <= 1'b0;
            auto_q  <= 1'b0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            setp_q  <= 1'b0;
            shift_q <= '0;
            shen_q  <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            left_q  <= left_d;
            len_q   <= len_d;
            cen_q   <= cen_d;
            auto_q  <= auto_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            setp_q  <= setp_d;
            shift_q <= shift_d;
            shen_q  <= shen_d;
            set_q   <= set_d;
        end
    end

    assign wbs_ack_o      = ack_q;
    assign wbs_data_o     = rdata_q;
    assign cfg_cen_o      = cen_q;
    assign cfg_shift_o    = shift_q;
    assign cfg_shift_en_o = shen_q;
    assign cfg_set_o      = set_q;
endmodule

// File: tb/tb_wb_config_ctrl.sv
// Self-checking bench for wb_config_ctrl: directed scenarios plus randomized words
// compared against a bit-list model of the serial column stream.
module tb_wb_config_ctrl;
    localparam int unsigned NC = 8;
    localparam logic [31:0] B  = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   addr = '0, wdata = '0;
    logic          ack;
    logic [31:0]   rdata;
    logic          cen;
    logic [NC-1:0] sh, en, set;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;

    typedef struct { int cyc; logic [NC-1:0] en; logic [NC-1:0] sh; } ev_t;
    ev_t sh_q[$];
    ev_t set_q[$];

    wb_config_ctrl #(.NUM_COLS(NC), .BASE_ADDR(B)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_addr_i(addr), .wbs_data_i(wdata),
        .wbs_ack_o(ack), .wbs_data_o(rdata), .cfg_cen_o(cen),
        .cfg_shift_o(sh), .cfg_shift_en_o(en), .cfg_set_o(set)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (en != '0 || sh != '0) sh_q.push_back('{cyc_n, en, sh});
        if (set != '0) set_q.push_back('{cyc_n, set, '0});
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output int ack_at);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; sel = s; wdata = d;
        ack_at = -1; rd = '0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (ack) begin ack_at = cyc_n; rd = rdata; break; end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_chk++;
        if (ack_at < 0) begin
            n_fail++;
            $display("FAIL wb_ack_timeout: addr %h got no ack, required ack within 200 cycles", a);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] r; int a;
        wb_xfer(1'b1, B + off, 4'hF, d, r, a);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] r);
        int a;
        wb_xfer(1'b0, B + off, 4'hF, '0, r, a);
    endtask

    task automatic test_reset;
        logic [31:0] r; int a, start; bit seen;
        rst = 1'b1; cycles(3);
        n_chk++;
        if ({ack, rdata, cen, sh, en, set} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0", {ack, rdata, cen, sh, en, set});
        end
        rst = 1'b0; cycles(1);
        start = cyc_n;
        wb_xfer(1'b0, B + 32'hC, 4'hF, '0, r, a);
        n_chk++;
        if (a != start + 1) begin n_fail++; $display("FAIL status_latency: got %0d required %0d", a - start, 1); end
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL status_reset: got %h required 0", r); end
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = B + 32'h10; sel = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack || rdata != '0) seen = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL miss_no_ack: got ack/data activity required none"); end
    endtask

    task automatic test_autoset;
        logic [31:0] r, word; int a;
        word = 32'hA5A5_0F0F;
        wr(32'h0, 32'h0000_1F05);
        wr(32'h4, 32'hFFFF_FF05);
        begin logic [31:0] x; int y; wb_xfer(1'b1, B + 32'h4, 4'b1110, 32'h0000_00FF, x, y); end
        rd(32'h4, r);
        n_chk++;
        if (r !== 32'h0000_0005) begin n_fail++; $display("FAIL mask_readback: got %h required %h", r, 32'h5); end
        rd(32'h0, r);
        n_chk++;
        if (r !== 32'h0000_1F05) begin n_fail++; $display("FAIL ctrl_readback: got %h required %h", r, 32'h1F05); end
        rd(32'h8, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL data_read_zero: got %h required 0", r); end
        sh_q.delete(); set_q.delete();
        wb_xfer(1'b1, B + 32'h8, 4'hF, word, r, a);
        cycles(40);
        n_chk++;
        if (sh_q.size() != 32) begin n_fail++; $display("FAIL auto_bitcount: got %0d required 32", sh_q.size()); end
        for (int i = 0; i < 32; i++) begin
            if (i < sh_q.size()) begin
                n_chk++;
                if (sh_q[i].cyc != a + 1 + i || sh_q[i].en !== 8'h05 ||
                    sh_q[i].sh !== (word[i] ? 8'h05 : 8'h00)) begin
                    n_fail++;
                    $display("FAIL auto_bit%0d: got cyc %0d en %h sh %h required cyc %0d en 05 sh %h",
                             i, sh_q[i].cyc, sh_q[i].en, sh_q[i].sh, a + 1 + i, word[i] ? 8'h05 : 8'h00);
                end
            end
        end
        n_chk++;
        if (set_q.size() != 1 || set_q[0].cyc != a + 33 || set_q[0].en !== 8'h05) begin
            n_fail++; $display("FAIL auto_set_pulse: got %0d pulses required one of 05 at cycle %0d", set_q.size(), a + 33);
        end
        rd(32'hC, r);
        n_chk++;
        if (r !== 32'h0020_0000) begin n_fail++; $display("FAIL auto_status: got %h required %h", r, 32'h0020_0000); end
    endtask

    task automatic test_short;
        logic [31:0] r, word; int a, p, hitc;
        int exp_bits[4] = '{1, 1, 0, 1};
        word = 32'hB;
        wr(32'h0, 32'h0000_0308);
        wr(32'h0, 32'h0000_0301);
        wr(32'h4, 32'h0000_00C3);
        sh_q.delete(); set_q.delete();
        wb_xfer(1'b1, B + 32'h8, 4'hF, word, r, a);
        for (int k = 0; k < 4; k++) begin
            wb_xfer(1'b0, B + 32'hC, 4'hF, '0, r, p);
            hitc = p - 1;
            n_chk++;
            if (r[0] !== ((hitc >= a + 1 && hitc <= a + 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL short_busy_at_%0d: got %b required %b", hitc - a, r[0], (hitc <= a + 4));
            end
        end
        cycles(4);
        n_chk++;
        if (sh_q.size() != 4) begin n_fail++; $display("FAIL short_bitcount: got %0d required 4", sh_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < sh_q.size()) begin
                n_chk++;
                if (sh_q[i].cyc != a + 1 + i || sh_q[i].sh !== (exp_bits[i] != 0 ? 8'hC3 : 8'h00)) begin
                    n_fail++; $display("FAIL short_bit%0d: got sh %h required %h", i, sh_q[i].sh, exp_bits[i] != 0 ? 8'hC3 : 8'h00);
                end
            end
        end
        n_chk++;
        if (set_q.size() != 0) begin n_fail++; $display("FAIL short_no_set: got %0d pulses required 0", set_q.size()); end
        rd(32'hC, r);
        n_chk++;
        if (r !== 32'h0004_0000) begin n_fail++; $display("FAIL short_status: got %h required %h", r, 32'h0004_0000); end
    endtask

    task automatic test_manual_set;
        logic [31:0] r; int a;
        set_q.delete();
        wb_xfer(1'b1, B + 32'h0, 4'hF, 32'h0000_0003, r, a);
        cycles(3);
        n_chk++;
        if (set_q.size() != 1 || set_q[0].cyc != a + 1 || set_q[0].en !== 8'hC3) begin
            n_fail++; $display("FAIL manual_set: got %0d pulses required one of c3 at cycle %0d", set_q.size(), a + 1);
        end
        rd(32'h0, r);
        n_chk++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL set_reads_zero: got %h required 1", r); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r, w1, w2; int a1, a2, len, au, n, ec;
        logic eb;
        for (int k = 0; k < 2; k++) begin
            len = $urandom_range(0, 15); au = k;
            w1 = $urandom(); w2 = $urandom();
            wr(32'h0, (32'(len) << 8) | (32'(au) << 2) | 32'h9);
            wr(32'h4, 32'hFF);
            sh_q.delete(); set_q.delete();
            wb_xfer(1'b1, B + 32'h8, 4'hF, w1, r, a1);
            wb_xfer(1'b1, B + 32'h8, 4'hF, w2, r, a2);
            n_chk++;
            if (a2 != a1 + len + 1 + au) begin
                n_fail++; $display("FAIL bp_ack_delay: got %0d required %0d", a2 - a1, len + 1 + au);
            end
            cycles(len + 6);
            n = 2 * (len + 1);
            n_chk++;
            if (sh_q.size() != n) begin n_fail++; $display("FAIL bp_bitcount: got %0d required %0d", sh_q.size(), n); end
            for (int i = 0; i < n && i < sh_q.size(); i++) begin
                ec = (i <= len) ? a1 + 1 + i : a2 + 1 + (i - len - 1);
                eb = (i <= len) ? w1[i] : w2[i - len - 1];
                n_chk++;
                if (sh_q[i].cyc != ec || sh_q[i].sh !== (eb ? 8'hFF : 8'h00)) begin
                    n_fail++; $display("FAIL bp_bit%0d: got cyc %0d sh %h required cyc %0d bit %b", i, sh_q[i].cyc, sh_q[i].sh, ec, eb);
                end
            end
            n_chk++;
            if (set_q.size() != 2 * au) begin n_fail++; $display("FAIL bp_sets: got %0d required %0d", set_q.size(), 2 * au); end
            rd(32'hC, r);
            n_chk++;
            if (r !== {16'(n), 16'h0}) begin n_fail++; $display("FAIL bp_status: got %h required %h", r, {16'(n), 16'h0}); end
        end
    endtask

    task automatic test_errors;
        logic [31:0] r; int a;
        wr(32'h0, 32'h0000_0308);
        sh_q.delete();
        wr(32'h8, 32'hFFFF_FFFF);
        cycles(8);
        rd(32'hC, r);
        n_chk++;
        if (sh_q.size() != 0 || r !== 32'h2) begin n_fail++; $display("FAIL err_cen0: got %0d bits status %h required 0 bits status 2", sh_q.size(), r); end
        wr(32'h0, 32'h0000_0309);
        rd(32'hC, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL err_clear: got %h required 0", r); end
        wb_xfer(1'b1, B + 32'h8, 4'h3, 32'hFFFF_FFFF, r, a);
        cycles(8);
        rd(32'hC, r);
        n_chk++;
        if (sh_q.size() != 0 || r !== 32'h2) begin n_fail++; $display("FAIL err_sel: got %0d bits status %h required 0 bits status 2", sh_q.size(), r); end
        wr(32'h0, 32'h0000_1F09);
        sh_q.delete(); set_q.delete();
        wb_xfer(1'b1, B + 32'h8, 4'hF, 32'h1234_5678, r, a);
        wr(32'h0, 32'h0000_1F0B);
        cycles(40);
        rd(32'hC, r);
        n_chk++;
        if (set_q.size() != 0 || sh_q.size() != 32) begin
            n_fail++; $display("FAIL err_set_busy: got %0d pulses %0d bits required 0 pulses 32 bits", set_q.size(), sh_q.size());
        end
        n_chk++;
        if (r !== 32'h001E_0002) begin n_fail++; $display("FAIL err_set_clear_race: got %h required %h", r, 32'h001E_0002); end
        wr(32'h0, 32'h0000_1F09);
        rd(32'hC, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL err_final_clear: got %h required 0", r); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r, word; int a;
        wr(32'h0, 32'h0000_1F05);
        wr(32'h4, 32'h0000_0005);
        sh_q.delete();
        wb_xfer(1'b1, B + 32'h8, 4'hF, 32'hFFFF_FFFF, r, a);
        while (cyc_n < a + 10) cycles(1);
        rst = 1'b1; cycles(1);
        n_chk++;
        if ({ack, rdata, cen, sh, en, set} !== '0 || sh_q.size() != 10) begin
            n_fail++; $display("FAIL midreset_outputs: got %h after %0d bits required 0 after 10", {ack, rdata, cen, sh, en, set}, sh_q.size());
        end
        rst = 1'b0; cycles(1);
        rd(32'hC, r);
        n_chk++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL midreset_status: got %h required 0", r); end
        word = $urandom();
        wr(32'h0, 32'h0000_1F05);
        wr(32'h4, 32'h0000_0005);
        sh_q.delete(); set_q.delete();
        wb_xfer(1'b1, B + 32'h8, 4'hF, word, r, a);
        cycles(40);
        n_chk++;
        if (sh_q.size() != 32 || set_q.size() != 1) begin n_fail++; $display("FAIL midreset_resume: got %0d bits %0d sets required 32 and 1", sh_q.size(), set_q.size()); end
        for (int i = 0; i < 32 && i < sh_q.size(); i++) begin
            n_chk++;
            if (sh_q[i].sh !== (word[i] ? 8'h05 : 8'h00)) begin
                n_fail++; $display("FAIL midreset_bit%0d: got %h required %h", i, sh_q[i].sh, word[i] ? 8'h05 : 8'h00);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] r, word; int a, len, au, total;
        logic [NC-1:0] m;
        total = 0;
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(0, 31); au = $urandom_range(0, 1);
            m = NC'($urandom_range(1, 255)); word = $urandom();
            wr(32'h0, (32'(len) << 8) | (32'(au) << 2) | 32'h1 | (k == 0 ? 32'h8 : 32'h0));
            wr(32'h4, 32'(m));
            sh_q.delete(); set_q.delete();
            wb_xfer(1'b1, B + 32'h8, 4'hF, word, r, a);
            cycles(len + 5);
            total += len + 1;
            n_chk++;
            if (sh_q.size() != len + 1) begin n_fail++; $display("FAIL rnd%0d_bitcount: got %0d required %0d", k, sh_q.size(), len + 1); end
            for (int i = 0; i <= len && i < sh_q.size(); i++) begin
                n_chk++;
                if (sh_q[i].cyc != a + 1 + i || sh_q[i].en !== m || sh_q[i].sh !== (word[i] ? m : '0)) begin
                    n_fail++; $display("FAIL rnd%0d_bit%0d: got en %h sh %h required en %h sh %h", k, i, sh_q[i].en, sh_q[i].sh, m, word[i] ? m : '0);
                end
            end
            n_chk++;
            if (set_q.size() != au || (au == 1 && (set_q[0].cyc != a + len + 2 || set_q[0].en !== m))) begin
                n_fail++; $display("FAIL rnd%0d_set: got %0d pulses required %0d at cycle %0d", k, set_q.size(), au, a + len + 2);
            end
            rd(32'hC, r);
            n_chk++;
            if (r !== {16'(total), 16'h0}) begin n_fail++; $display("FAIL rnd%0d_status: got %h required %h", k, r, {16'(total), 16'h0}); end
        end
    endtask

    initial begin
        cycles(1);
        test_reset();
        test_autoset();
        test_short();
        test_manual_set();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_config_ctrl.md
# wb_config_ctrl

Parametrised Wishbone configuration controller that replaces the fixed two-region configurator pair feeding the fabric's per-column configuration chains. It decodes a 16-byte register window on the Caravel Wishbone slave bus, serialises 32-bit data words LSB-first onto a masked subset of `NUM_COLS` column chains, and issues column set pulses. It has backpressure, variable-length shifts, optional auto-set and status readback. Several instances may share the bus; their `wbs_data_o`/`wbs_ack_o` are OR-combined at the top level.

## Interface
- `NUM_COLS`, 8: number of configuration columns driven (1..32).
- `BASE_ADDR`, 32'h3000_0000: window base; must be 16-byte aligned.
- `wb_clk_i` in 1: the single clock; also the fabric clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic cycle, strobe and write enable.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_addr_i` in 32: byte address.
- `wbs_data_i` in 32: write data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_data_o` out 32: read data; zero when not acking.
- `cfg_cen_o` out 1: configuration enable to all columns.
- `cfg_shift_o` out NUM_COLS: serial configuration bit per column.
- `cfg_shift_en_o` out NUM_COLS: per-column shift qualifier.
- `cfg_set_o` out NUM_COLS: per-column one-cycle latch pulse.

## Operation
- Hit: `wbs_addr_i[31:4] == BASE_ADDR[31:4]` with `cyc & stb`. Offset is `addr[3:2]`. On a miss, no ack is issued and `wbs_data_o` = 0.
- Register map:
  - 0x0 CTRL (RW):
    - [0] cen.
    - [1] set strobe: write-1 pulses, reads 0.
    - [2] auto_set.
    - [3] clear status: write-1, reads 0.
    - [12:8] len: bits per word minus 1.
  - 0x4 MASK (RW): [NUM_COLS-1:0] column mask; upper bits read 0.
  - 0x8 DATA (W): shift word. Reads return 0.
  - 0xC STATUS (R):
    - [0] busy.
    - [1] err (sticky).
    - [31:16] bit count, saturating at 0xFFFF.
    - Writes to STATUS are ignored.
- Byte lanes: CTRL and MASK writes honour `wbs_sel_i` per byte. A DATA write with `sel != 4'hF` is acked and ignored, and sets err.
- FSM has three states:
  - IDLE: accepting a DATA write loads the shift register and counter = len, then goes to SHIFT.
  - SHIFT: each cycle, `cfg_shift_o[c] = sr[0]` for all c. `cfg_shift_en_o = MASK`. sr shifts right and bit count increments. After len+1 cycles, go to SETP if auto_set, else IDLE.
  - SETP: `cfg_set_o = MASK` for one cycle, then IDLE.
- Manual set (CTRL[1] written as 1) is applied only in IDLE: `cfg_set_o = MASK` on the cycle after the ack. If written while not IDLE, the write is ignored and err is set.
- A DATA write while cen = 0 is acked with no shift, and sets err.
- `cfg_shift_o` = 0 whenever `cfg_shift_en_o` = 0.
- MASK writes during SHIFT take effect on the next cycle (mid-word change permitted, software responsibility).

## Timing
- Reset values: all outputs 0. CTRL = 0, MASK = 0, err = 0, count = 0, state IDLE.
- Ack is registered:
  - Asserts the cycle after a hit with `!wbs_ack_o`, for exactly one cycle.
  - Read data is valid in the ack cycle.
  - Back-to-back requests are therefore acked every other cycle.
- Backpressure: a DATA write arriving while busy (SHIFT or SETP) is held un-acked. It is acked the cycle after the FSM returns to IDLE and loads the shift register in that ack cycle. CTRL, MASK and STATUS accesses are never stalled.
- Timing from the ack of a DATA write:
  - First shift bit appears in cycle A+1.
  - Last bit appears in cycle A+len+1.
  - Auto-set pulse occurs in cycle A+len+2.
  - busy reads 1 from A+1 through the final SHIFT or SETP cycle.
- Simultaneous events:
  - Clear status and bit increment in the same cycle: clear wins.
  - err set and clear in the same cycle: set wins.
- If the master drops `cyc` while stalled, the request is abandoned and no state changes.
- `wb_rst_i` mid-SHIFT or SETP: the next edge returns to IDLE, all outputs 0, and any pending ack is dropped.

## Test plan
- Reset then read STATUS at BASE+0xC: ack in 1 cycle, data 0. A read at BASE+0x10 gets no ack within 8 cycles and `wbs_data_o` = 0.
- Word shift with auto-set:
  - Setup: CTRL = 0x0000_1F05 (cen, auto_set, len 31), MASK = 0x05, DATA = 0xA5A5_0F0F.
  - Required: `cfg_shift_en_o` = 0x05 for 32 cycles, and the `cfg_shift_o[0]` sequence equals the word LSB-first.
  - Then `cfg_set_o` = 0x05 for one cycle, and STATUS count = 32.
- Short word: len = 3 (CTRL = 0x301), DATA = 0xB. Required: 4 bits (1,1,0,1) shifted, no set pulse, busy clears after 4 cycles.
- Backpressure: two consecutive DATA writes. Required: the second ack is withheld until the first word completes, and the second word's bits follow with no gap and no lost bits.
- Error paths, each setting err:
  - DATA write with cen = 0.
  - DATA write with sel = 4'h3.
  - Set strobe during SHIFT.
  - Writing CTRL[3] = 1 clears err and count.
- Reset during SHIFT, bit 10: outputs 0 next cycle, STATUS reads 0, and a new DATA write shifts normally.
